// File: rtl/exp_sum_accum.sv
// exp_sum_accum: streaming softmax denominator stage.
// Takes one vector of Q4.12 pow2 results, one element per beat, and sums them
// at full width. Negative elements count toward the length but add nothing.
// The vector closes on in_last or when MAX_LEN elements have arrived. The sum
// is then presented as a Q4.12 word, saturated to the largest positive value.
//
// Handshake: a transfer happens on a rising edge where valid && ready. The
// producer holds valid and its payload until that edge. The consumer may
// raise or drop ready freely. in_ready is high only while accumulating.
// out_valid is high only while a result is held, and out_* stay stable until
// the result is taken.
module exp_sum_accum #(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 12,
  parameter int MAX_LEN = 64,
  parameter int ACC_W   = DATA_W + $clog2(MAX_LEN),
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_sat,
  output logic [CNT_W-1:0]  out_len,
  output logic              out_trunc,
  output logic              dbg_state
);

  // Largest positive Q(INT_W).(FRAC_W) value, as a raw integer. This is 0x7FFF
  // for Q4.12.
  localparam int INT_W = DATA_W - FRAC_W;
  localparam logic [ACC_W-1:0] SAT_LIM = ACC_W'((1 << (INT_W - 1 + FRAC_W)) - 1);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;

  logic [ACC_W-1:0]   clamp_val;
  logic [ACC_W-1:0]   acc_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               hit_max;
  logic               over_lim;
  logic               beat_ok;
  logic               res_ok;

  // Next-value arithmetic for the beat currently offered on the input.
  always_comb begin
    clamp_val = '0;
    if (!in_data[DATA_W-1]) begin
      clamp_val = {{(ACC_W - DATA_W){1'b0}}, in_data};
    end
    acc_nxt  = acc + clamp_val;
    cnt_nxt  = cnt + 1'b1;
    hit_max  = (cnt_nxt == CNT_W'(MAX_LEN));
    over_lim = (acc_nxt > SAT_LIM);
    beat_ok  = in_valid && in_ready && (state == ST_ACCUM);
    res_ok   = out_valid && out_ready && (state == ST_DONE);
  end

  // Accumulate/hold FSM. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_ACCUM;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_sat   <= 1'b0;
      out_len   <= '0;
      out_trunc <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (beat_ok) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (in_last || hit_max) begin
              state     <= ST_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_sum   <= over_lim ? SAT_LIM[DATA_W-1:0] : acc_nxt[DATA_W-1:0];
              out_sat   <= over_lim;
              out_len   <= cnt_nxt;
              // An explicit in_last takes precedence over the length cap.
              out_trunc <= hit_max && !in_last;
            end
          end
        end
        ST_DONE: begin
          if (res_ok) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_trunc <= 1'b0;
          end
        end
        default: begin
          state <= ST_ACCUM;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_exp_sum_accum.sv
// Bench for exp_sum_accum: directed vectors plus randomized vectors compared
// against a plain-arithmetic reference of the vector sum.
module tb_exp_sum_accum;

  localparam int DATA_W  = 16;
  localparam int FRAC_W  = 12;
  localparam int MAX_LEN = 64;
  localparam int ACC_W   = DATA_W + $clog2(MAX_LEN);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam int RW      = 2 + CNT_W + DATA_W;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_sum;
  logic              out_sat;
  logic [CNT_W-1:0]  out_len;
  logic              out_trunc;
  logic              dbg_state;

  exp_sum_accum #(
    .DATA_W(DATA_W), .FRAC_W(FRAC_W), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat),
    .out_len(out_len), .out_trunc(out_trunc), .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: running sum of the clamped elements and the element count.
  // A closed vector pushes {trunc, sat, len, sum} onto the expected queue.
  longint          m_sum;
  int              m_cnt;
  logic [RW-1:0]   exp_q[$];
  logic [DATA_W-1:0] vec_q[$];
  bit              use_last;

  task automatic model_reset();
    m_sum = 0;
    m_cnt = 0;
  endtask

  task automatic model_beat(input logic [DATA_W-1:0] d, input bit last, output bit closed);
    logic [DATA_W-1:0] s;
    bit sat;
    bit trunc;
    m_cnt++;
    if (d[DATA_W-1] == 1'b0) m_sum += longint'(d);
    closed = last || (m_cnt == MAX_LEN);
    if (closed) begin
      sat   = (m_sum > 32767);
      s     = sat ? 16'h7FFF : 16'(m_sum);
      trunc = !last && (m_cnt == MAX_LEN);
      exp_q.push_back({trunc, sat, CNT_W'(m_cnt), s});
      model_reset();
    end
  endtask

  // Driver: offer one beat from a negedge, wait for in_ready, then take the edge.
  task automatic drive_beat(input logic [DATA_W-1:0] d, input bit last, output bit closed);
    int guard;
    guard  = 0;
    closed = 0;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    out_ready = 1'($urandom_range(0, 1));
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("beat_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    check("ov_before_accept", out_valid, 0);
    @(posedge clk);
    model_beat(d, last, closed);
  endtask

  task automatic check_fields(input string pfx, input logic [RW-1:0] e);
    check({pfx, "_sum"},   out_sum,   e[DATA_W-1:0]);
    check({pfx, "_len"},   out_len,   e[DATA_W+CNT_W-1:DATA_W]);
    check({pfx, "_sat"},   out_sat,   e[RW-2]);
    check({pfx, "_trunc"}, out_trunc, e[RW-1]);
    check({pfx, "_valid"}, out_valid, 1);
    check({pfx, "_inrdy"}, in_ready,  0);
  endtask

  // Scoreboard side: result must be present the cycle after the closing beat,
  // stay stable under backpressure, then clear on acceptance.
  task automatic check_result(input int hold);
    logic [RW-1:0] e;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'($urandom_range(0, 1));
    in_data   = DATA_W'($urandom);
    in_last   = 1'($urandom_range(0, 1));
    check("latency_valid", out_valid, 1);
    check("dbg_state_done", dbg_state, 1);
    if (exp_q.size() == 0) begin
      check("exp_empty", 0, 1);
      return;
    end
    e = exp_q.pop_front();
    check_fields("res", e);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      check_fields("hold", e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("acc_valid_clr", out_valid, 0);
    check("acc_inrdy_set", in_ready, 1);
    check("acc_trunc_clr", out_trunc, 0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic run_vector(input int hold);
    bit closed;
    int g;
    closed = 0;
    for (int i = 0; i < vec_q.size(); i++) begin
      drive_beat(vec_q[i], use_last && (i == vec_q.size() - 1), closed);
      if (closed) break;
      if ($urandom_range(0, 3) == 0) begin
        g = $urandom_range(1, 3);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DATA_W'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        repeat (g - 1) @(negedge clk);
      end
    end
    if (closed) check_result(hold);
    else check("vector_closed", 0, 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_valid"}, out_valid, 0);
    check({pfx, "_inrdy"}, in_ready,  1);
    check({pfx, "_sum"},   out_sum,   0);
    check({pfx, "_len"},   out_len,   0);
    check({pfx, "_sat"},   out_sat,   0);
    check({pfx, "_trunc"}, out_trunc, 0);
  endtask

  task automatic pulse_reset(input string pfx);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_outputs(pfx);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Main sequence
  initial begin
    bit closed;
    int len;
    int mode;
    logic [DATA_W-1:0] d;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_dbg_state", dbg_state, 0);
    rst_n = 1'b1;

    // 1.0 + 0.5 + 0.25 + 0.125 = 0x1E00
    vec_q = '{16'h1000, 16'h0800, 16'h0400, 16'h0200};
    use_last = 1;
    run_vector(1);

    // twelve 1.0 beats saturate
    vec_q.delete();
    for (int i = 0; i < 12; i++) vec_q.push_back(16'h1000);
    use_last = 1;
    run_vector(0);

    // length cap without in_last
    vec_q.delete();
    for (int i = 0; i < MAX_LEN; i++) vec_q.push_back(16'h0001);
    use_last = 0;
    run_vector(2);

    // in_last on the MAX_LEN-th beat: not truncated
    vec_q.delete();
    for (int i = 0; i < MAX_LEN; i++) vec_q.push_back(16'h0010);
    use_last = 1;
    run_vector(0);

    // backpressure for 5 cycles, then next vector starts from zero
    vec_q = '{16'h0100, 16'h0200};
    use_last = 1;
    run_vector(5);
    vec_q = '{16'h0300};
    use_last = 1;
    run_vector(0);

    // negative element clamped to zero
    vec_q = '{16'hF000, 16'h1000};
    use_last = 1;
    run_vector(1);

    // reset after 3 of 5 beats
    for (int i = 0; i < 3; i++) drive_beat(16'h1000, 1'b0, closed);
    pulse_reset("rst_mid");
    vec_q = '{16'h0400};
    use_last = 1;
    run_vector(0);

    // reset while holding a result
    drive_beat(16'h2000, 1'b0, closed);
    drive_beat(16'h2000, 1'b1, closed);
    @(negedge clk);
    out_ready = 1'b0;
    check("rst_done_valid", out_valid, 1);
    pulse_reset("rst_done");
    vec_q = '{16'h0123, 16'h0001};
    use_last = 1;
    run_vector(0);

    // randomized vectors
    for (int v = 0; v < 30; v++) begin
      vec_q.delete();
      use_last = ($urandom_range(0, 3) != 0);
      len  = use_last ? $urandom_range(1, MAX_LEN) : MAX_LEN + 2;
      mode = $urandom_range(0, 2);
      for (int i = 0; i < len; i++) begin
        case (mode)
          0:       d = DATA_W'($urandom_range(0, 16'h0400));
          1:       d = DATA_W'($urandom_range(0, 16'h7FFF));
          default: d = DATA_W'($urandom_range(0, 16'h0100));
        endcase
        if ($urandom_range(0, 4) == 0) d = DATA_W'($urandom_range(16'h8000, 16'hFFFF));
        vec_q.push_back(d);
      end
      run_vector($urandom_range(0, 3));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
